// File: rtl/uart_tx_unit.sv
// UART transmitter: free-running sampling-tick generator plus a start/data/stop framing FSM.
// Optional even-parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_tx_unit #(
   parameter int DATA_SIZE = 8,
   parameter int SYS_FREQ  = 50000000,
   parameter int BAUD_RATE = 115200,
   parameter int SAMPLE    = 16,
   parameter int BAUD_DVSR = SYS_FREQ / (SAMPLE * BAUD_RATE)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 tx_start,
   input  logic [DATA_SIZE-1:0] data_in,
   output logic                 tx,
   output logic                 tx_done_tick,
   output logic                 s_tick
);

   localparam int DVSR_W = (BAUD_DVSR > 1) ? $clog2(BAUD_DVSR) : 1;
   localparam int TICK_W = (SAMPLE > 1) ? $clog2(SAMPLE) : 1;
   localparam int BIT_W  = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;

   localparam logic [DVSR_W-1:0] DVSR_LAST = DVSR_W'(BAUD_DVSR - 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_SIZE - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t               state;
   logic [DVSR_W-1:0]    baud_cnt;
   logic [TICK_W-1:0]    tick_cnt;
   logic [BIT_W-1:0]     bit_cnt;
   logic [DATA_SIZE-1:0] shreg;
   logic [DATA_SIZE-1:0] shreg_shift;

`ifdef UART_TX_PARITY_EN
   logic parity_bit;

   function automatic logic even_parity(input logic [DATA_SIZE-1:0] d);
      return ^d;
   endfunction
`endif

   assign shreg_shift = shreg >> 1;

   // Tick generator: never realigned to a frame, so the start bit can be up to one tick short.
   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
         baud_cnt <= '0;
      end else if (baud_cnt == DVSR_LAST) begin
         baud_cnt <= '0;
      end else begin
         baud_cnt <= baud_cnt + DVSR_W'(1);
      end
   end

   assign s_tick = (baud_cnt == DVSR_LAST);

   // Framing FSM: tx is registered and set alongside each state change so the line never glitches.
   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
         state        <= IDLE;
         tick_cnt     <= '0;
         bit_cnt      <= '0;
         shreg        <= '0;
         tx           <= 1'b1;
         tx_done_tick <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_bit   <= 1'b0;
`endif
      end else begin
         tx_done_tick <= 1'b0;
         case (state)
            IDLE: begin
               tx <= 1'b1;
               if (tx_start) begin
                  shreg    <= data_in;
                  tick_cnt <= '0;
                  bit_cnt  <= '0;
                  tx       <= 1'b0;
                  state    <= START;
`ifdef UART_TX_PARITY_EN
                  parity_bit <= even_parity(data_in);
`endif
               end
            end
            START: begin
               if (s_tick) begin
                  if (tick_cnt == TICK_LAST) begin
                     tick_cnt <= '0;
                     tx       <= shreg[0];
                     state    <= DATA;
                  end else begin
                     tick_cnt <= tick_cnt + TICK_W'(1);
                  end
               end
            end
            DATA: begin
               if (s_tick) begin
                  if (tick_cnt == TICK_LAST) begin
                     tick_cnt <= '0;
                     shreg    <= shreg_shift;
                     if (bit_cnt == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        tx    <= parity_bit;
                        state <= PARITY;
`else
                        tx    <= 1'b1;
                        state <= STOP;
`endif
                     end else begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                        tx      <= shreg_shift[0];
                     end
                  end else begin
                     tick_cnt <= tick_cnt + TICK_W'(1);
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (s_tick) begin
                  if (tick_cnt == TICK_LAST) begin
                     tick_cnt <= '0;
                     tx       <= 1'b1;
                     state    <= STOP;
                  end else begin
                     tick_cnt <= tick_cnt + TICK_W'(1);
                  end
               end
            end
`endif
            STOP: begin
               if (s_tick) begin
                  if (tick_cnt == TICK_LAST) begin
                     tick_cnt     <= '0;
                     tx           <= 1'b1;
                     tx_done_tick <= 1'b1;
                     state        <= IDLE;
                  end else begin
                     tick_cnt <= tick_cnt + TICK_W'(1);
                  end
               end
            end
            default: begin
               tx    <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_unit.sv
// Scoreboard bench for uart_tx_unit at default parameters: stimulus queues expected frames,
// a line monitor decodes tx cycle-exactly and compares.
module tb_uart_tx_unit;

   localparam int DVSR     = 27;
   localparam int SAMPLE   = 16;
   localparam int BIT_CLKS = SAMPLE * DVSR;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 10;
`else
   localparam int NB = 9;
`endif

   logic       clk = 1'b0;
   logic       reset_n;
   logic       tx_start;
   logic [7:0] data_in;
   logic       tx;
   logic       tx_done_tick;
   logic       s_tick;

   uart_tx_unit dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .tx_start     (tx_start),
      .data_in      (data_in),
      .tx           (tx),
      .tx_done_tick (tx_done_tick),
      .s_tick       (s_tick)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] data;
      logic       b2b;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc;
   bit   busy = 1'b0;

   always @(posedge clk or posedge reset_n) begin
      if (reset_n) cyc <= 0;
      else         cyc <= cyc + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
      end
   endtask

   // line monitor
   initial begin
      int c0, first_edge, done_edge, last_done, k, off;
      exp_t cur;
      logic [NB-1:0] bits;
      last_done = -100;
      cur = '0;
      bits = '0;
      forever begin
         @(negedge clk);
         if (reset_n === 1'b1) begin
            busy = 1'b0;
         end else begin
            check("s_tick", s_tick, ((cyc % DVSR) == DVSR - 1));
            if (!busy) begin
               check("done_idle", tx_done_tick, 0);
               if (tx === 1'b0) begin
                  busy = 1'b1;
                  c0 = cyc;
                  first_edge = (c0 / DVSR + 1) * DVSR + (SAMPLE - 1) * DVSR;
                  done_edge = first_edge + NB * BIT_CLKS;
                  check("frame_expected", (exp_q.size() != 0), 1);
                  if (exp_q.size() != 0) cur = exp_q.pop_front();
`ifdef UART_TX_PARITY_EN
                  bits = {1'b1, ^cur.data, cur.data};
`else
                  bits = {1'b1, cur.data};
`endif
                  if (cur.b2b) check("b2b_gap", c0 - last_done, 1);
               end
            end else if (cyc < first_edge) begin
               check("done_in_frame", tx_done_tick, 0);
               if (cyc == c0 + 1 || cyc == first_edge - 1) check("start_bit", tx, 0);
            end else if (cyc < done_edge) begin
               check("done_in_frame", tx_done_tick, 0);
               k = (cyc - first_edge) / BIT_CLKS;
               off = (cyc - first_edge) % BIT_CLKS;
               if (off == 0 || off == BIT_CLKS / 2 || off == BIT_CLKS - 1)
                  check($sformatf("bit%0d_of_%02h", k, cur.data), tx, bits[k]);
            end else begin
               check("done_tick", tx_done_tick, 1);
               check("tx_after_stop", tx, 1);
               busy = 1'b0;
               last_done = cyc;
            end
         end
      end
   end

   task automatic send(input logic [7:0] d);
      exp_q.push_back('{data: d, b2b: 1'b0});
      data_in  = d;
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (tx_done_tick !== 1'b1 && n < budget);
      check("done_within_budget", tx_done_tick, 1);
   endtask

   // stimulus
   initial begin
      reset_n  = 1'b1;
      tx_start = 1'b0;
      data_in  = 8'h00;
      repeat (27) begin
         @(negedge clk);
         check("rst_tx", tx, 1);
         check("rst_done", tx_done_tick, 0);
         check("rst_s_tick", s_tick, 0);
      end
      reset_n = 1'b0;
      repeat (60) @(negedge clk);

      // 0xCB frame with a mid-frame attempt to start 0x5A that must be ignored
      send(8'hCB);
      repeat (2000) @(negedge clk);
      data_in  = 8'h5A;
      tx_start = 1'b1;
      @(negedge clk);
      tx_start = 1'b0;
      wait_done(5000);
      repeat (1500) @(negedge clk);

      // back-to-back frames with tx_start held high
      exp_q.push_back('{data: 8'hA5, b2b: 1'b0});
      exp_q.push_back('{data: 8'h00, b2b: 1'b1});
      exp_q.push_back('{data: 8'hFF, b2b: 1'b1});
      data_in  = 8'hA5;
      tx_start = 1'b1;
      wait_done(5000);
      data_in = 8'h00;
      wait_done(5000);
      data_in = 8'hFF;
      @(negedge clk);
      tx_start = 1'b0;
      wait_done(5000);
      repeat (100) @(negedge clk);

      // asynchronous reset in the middle of the data bits
      send(8'h96);
      repeat (1500) @(negedge clk);
      #2 reset_n = 1'b1;
      #1;
      check("abort_tx", tx, 1);
      check("abort_done", tx_done_tick, 0);
      exp_q.delete();
      repeat (5) @(negedge clk);
      reset_n = 1'b0;
      repeat (50) begin
         @(negedge clk);
         check("post_reset_idle", tx, 1);
      end

      send(8'h3C);
      wait_done(5000);
      repeat (20) @(negedge clk);
      check("queue_empty", exp_q.size(), 0);
      check("monitor_idle", busy, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish (checks %0d errors %0d)", checks, errors);
      $fatal(1);
   end

endmodule
